// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Cycles through four slots, each preceded by a blanking gap to stop ghosting.
// Inputs are sampled once per frame so a frame never shows a mix of old and
// new values.
module seg_scan_ctrl #(
   parameter int unsigned DIV_BITS     = 17,
   parameter int unsigned BLANK_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [15:0] digits,
   input  logic [3:0]  digit_en,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   typedef enum logic [0:0] {StBlank, StShow} state_e;

   localparam logic [DIV_BITS-1:0] BlankLast = DIV_BITS'(BLANK_CYCLES - 1);
   localparam logic [DIV_BITS-1:0] One       = DIV_BITS'(1);

   state_e              state_q, state_d;
   logic [DIV_BITS-1:0] presc_q, presc_d;
   logic [DIV_BITS-1:0] blank_cnt_q, blank_cnt_d;
   logic [1:0]          idx_q, idx_d;
   logic [15:0]         sh_digits_q, sh_digits_d;
   logic [3:0]          sh_en_q, sh_en_d;
   logic [3:0]          sh_dp_q, sh_dp_d;
   logic [3:0]          an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic                fd_q, fd_d;
   logic                tick;

   // Active-low font, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick = &presc_q;

   // Next-state: prescaler, blank timer, slot index, frame snapshot.
   always_comb begin
      presc_d     = presc_q + One;
      state_d     = state_q;
      blank_cnt_d = blank_cnt_q;
      idx_d       = idx_q;
      sh_digits_d = sh_digits_q;
      sh_en_d     = sh_en_q;
      sh_dp_d     = sh_dp_q;
      fd_d        = 1'b0;
      unique case (state_q)
         StBlank: begin
            if (blank_cnt_q == BlankLast) begin
               state_d     = StShow;
               blank_cnt_d = '0;
               if (idx_q == 2'd0) begin
                  sh_digits_d = digits;
                  sh_en_d     = digit_en;
                  sh_dp_d     = dp_in;
               end
            end else begin
               blank_cnt_d = blank_cnt_q + One;
            end
         end
         StShow: begin
            // Ticks seen during blanking are dropped; a slot ends only on a tick.
            if (tick) begin
               state_d = StBlank;
               idx_d   = idx_q + 2'd1;
               fd_d    = (idx_q == 2'd3);
            end
         end
         default: state_d = StBlank;
      endcase
   end

   // Output decode from the next state so outputs move on the same edge as the FSM.
   always_comb begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (state_d == StShow) begin
         an_d[idx_d] = ~sh_en_d[idx_d];
         seg_d       = hex7(sh_digits_d[{idx_d, 2'b00} +: 4]);
         dp_d        = ~sh_dp_d[idx_d];
      end
   end

   // State and registered outputs; clr blanks everything immediately.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         presc_q     <= '0;
         state_q     <= StBlank;
         blank_cnt_q <= '0;
         idx_q       <= 2'd0;
         sh_digits_q <= 16'h0000;
         sh_en_q     <= 4'h0;
         sh_dp_q     <= 4'h0;
         an_q        <= 4'b1111;
         seg_q       <= 7'h7F;
         dp_q        <= 1'b1;
         fd_q        <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         state_q     <= state_d;
         blank_cnt_q <= blank_cnt_d;
         idx_q       <= idx_d;
         sh_digits_q <= sh_digits_d;
         sh_en_q     <= sh_en_d;
         sh_dp_q     <= sh_dp_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         fd_q        <= fd_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The module SHALL have parameter DIV_BITS, default 17, setting the scan-tick period to 2^DIV_BITS clk cycles (381.47 Hz at 50 MHz).
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 1024, setting the inter-digit blanking length in clk cycles; legal range 1 <= BLANK_CYCLES < 2^DIV_BITS.
REQ-003 Port clk  input  1  master clock (50 MHz); the only clock.
REQ-004 Port clr  input  1  reset, asynchronous, active-high.
REQ-005 Port digits  input  16  four hex digits; slot k uses digits[4k+3:4k].
REQ-006 Port digit_en  input  4  per-slot enable; 0 keeps that slot's anode off.
REQ-007 Port dp_in  input  4  per-slot decimal point request, 1 = lit.
REQ-008 Port an  output  4  anode drives, active-low; an[k] drives slot k.
REQ-009 Port seg  output  7  segment drives {g,f,e,d,c,b,a}, active-low.
REQ-010 Port dp  output  1  decimal point drive, active-low.
REQ-011 Port frame_done  output  1  one-cycle pulse at end of each 4-slot frame.

Function
REQ-012 Free-running DIV_BITS-bit prescaler SHALL increment every clk, wrap to 0; tick = 1 for the cycle prescaler is all-ones.
REQ-013 FSM states SHALL be BLANK and SHOW; 2-bit slot index idx.
REQ-014 In BLANK: an = 4'b1111, seg = 7'h7F, dp = 1; state lasts exactly BLANK_CYCLES cycles, then -> SHOW.
REQ-015 On BLANK -> SHOW with idx == 0: snapshot digits, digit_en, dp_in into shadow registers; slots display only shadow values (no mid-frame tearing).
REQ-016 In SHOW: an[idx] = ~shadow_en[idx], other anodes 1; seg = hex decode of shadow digit idx; dp = ~shadow_dp[idx].
REQ-017 Hex decode SHALL be standard font 0-9, A, b, C, d, E, F (e.g. 0 -> 7'h40, 4 -> 7'h19, 3 -> 7'h30, 8 -> 7'h00, F -> 7'h0E).
REQ-018 Disabled slot SHALL keep all anodes off for its full SHOW period; slot timing unchanged.
REQ-019 In SHOW, tick SHALL cause -> BLANK and idx <= idx + 1 mod 4 (3 wraps to 0).
REQ-020 Tick during BLANK SHALL be ignored; SHOW persists until the next tick.
REQ-021 frame_done SHALL pulse 1 cycle, coincident with the SHOW -> BLANK transition when idx == 3.
REQ-022 an, seg, dp, frame_done SHALL be registered; they change on the same clk edge as the state change.
REQ-023 Input changes SHALL never alter outputs except via the idx == 0 snapshot.

Reset
REQ-024 While clr = 1 (immediately, no clk edge needed): prescaler 0, state BLANK, blank counter 0, idx 0, shadows 0, an = 4'b1111, seg = 7'h7F, dp = 1, frame_done = 0.
REQ-025 After clr falls, first SHOW SHALL begin BLANK_CYCLES cycles later with idx 0 and a fresh snapshot.
REQ-026 clr asserted mid-SHOW or mid-BLANK SHALL blank outputs at once and restart per REQ-025.

Verification (DIV_BITS = 4, BLANK_CYCLES = 2)
REQ-027 clr = 1 with no clk activity -> an = 1111, seg = 7F, dp = 1, frame_done = 0.
REQ-028 digits = 16'h1234, digit_en = 1111, dp_in = 0000, release clr -> 2 cycles blank, then an = 1110 / seg = 19 until tick; 2 blank cycles; then an = 1101 / seg = 30.
REQ-029 Change digits to 16'hFFFF while idx = 1 -> slots 1-3 still show 3, 2, 1; slot 0 of next frame shows F (seg = 0E).
REQ-030 digit_en = 1011 -> an = 1111 during the whole slot-2 SHOW; slot-3 SHOW starts at the same cycle as with all slots enabled.
REQ-031 Steady run -> frame_done pulses exactly once per 64 cycles, always on a SHOW -> BLANK edge with idx = 3; dp_in = 0001 -> dp = 0 only in slot 0.
REQ-032 Assert clr mid-SHOW between clk edges -> outputs blank asynchronously; after release, sequence restarts per REQ-028 timing.
